tt_load_drain_ctrl: RTL

- Sequencer between the scoreboard's load-drain request interface and the load-queue read/writeback path.
- Accepts one drain request at a time: scoreboard ID, LQ entry count and starting LQ ID.
- Walks the LQ entries in order with wrap-around and issues one read per handshake.
- Holds the draining handshake low for exactly one cycle at the end so the scoreboard marks the entry drained.

---
 rtl/tt_vpu_ovi_pkg.sv | 21 ++
 rtl/tt_load_drain_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/tt_vpu_ovi_pkg.sv
// Shared constants and types for the load-drain sequencer.
package tt_vpu_ovi_pkg;

  localparam int unsigned LQ_DEPTH = 8;
  localparam int unsigned LQID_W   = 3;
  localparam int unsigned SB_ID_W  = 5;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FINISH = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic [SB_ID_W-1:0] sb_id;
    logic [CNT_W-1:0]   ref_count;
    logic [LQID_W-1:0]  lqid_start;
  } drain_req_t;

endpackage

// File: rtl/tt_load_drain_ctrl.sv
// Load-drain sequencer: accepts one scoreboard drain request, walks its LQ
// entries in order (wrapping), issues one read per handshake, then pulses done.
module tt_load_drain_ctrl
  import tt_vpu_ovi_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_drain_req,
  input  logic [SB_ID_W-1:0]  i_drain_sb_id,
  input  logic [CNT_W-1:0]    i_drain_ref_count,
  input  logic [LQID_W-1:0]   i_drain_lqid_start,
  output logic                o_draining,
  input  logic [LQ_DEPTH-1:0] i_lq_valid,
  output logic                o_rd_valid,
  output logic [LQID_W-1:0]   o_rd_lqid,
  output logic                o_rd_last,
  input  logic                i_rd_ready,
  output logic                o_done,
  output logic [SB_ID_W-1:0]  o_done_sb_id,
  output logic                o_busy
);

  drain_state_e       state, state_nxt;
  logic [LQID_W-1:0]  cur_lqid, cur_lqid_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic [SB_ID_W-1:0] sb_id_q, sb_id_nxt;
  drain_req_t         req;
  logic               rd_valid;
  logic               xfer;

  assign req = '{sb_id: i_drain_sb_id, ref_count: i_drain_ref_count,
                 lqid_start: i_drain_lqid_start};

  assign o_busy = (state != IDLE);

  // State and per-load context registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_lqid  <= '0;
      remaining <= '0;
      sb_id_q   <= '0;
    end else begin
      state     <= state_nxt;
      cur_lqid  <= cur_lqid_nxt;
      remaining <= remaining_nxt;
      sb_id_q   <= sb_id_nxt;
    end
  end

  // Next-state, context update and handshake outputs.
  always_comb begin
    state_nxt     = state;
    cur_lqid_nxt  = cur_lqid;
    remaining_nxt = remaining;
    sb_id_nxt     = sb_id_q;
    rd_valid      = 1'b0;
    xfer          = 1'b0;
    o_draining    = 1'b0;
    o_rd_valid    = 1'b0;
    o_rd_lqid     = '0;
    o_rd_last     = 1'b0;
    o_done        = 1'b0;
    o_done_sb_id  = '0;

    case (state)
      IDLE: begin
        // Echo the request so the scoreboard never sees "complete" on accept;
        // forced low while reset is asserted.
        o_draining = i_drain_req & reset_n;
        if (i_drain_req) begin
          cur_lqid_nxt  = req.lqid_start;
          remaining_nxt = req.ref_count;
          sb_id_nxt     = req.sb_id;
          state_nxt     = (req.ref_count == '0) ? FINISH : ACTIVE;
        end
      end
      ACTIVE: begin
        rd_valid   = i_lq_valid[cur_lqid];
        xfer       = rd_valid & i_rd_ready;
        o_draining = 1'b1;
        o_rd_valid = rd_valid;
        o_rd_lqid  = cur_lqid;
        o_rd_last  = (remaining == CNT_W'(1));
        if (xfer) begin
          cur_lqid_nxt  = cur_lqid + LQID_W'(1);
          remaining_nxt = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nxt = FINISH;
          end
        end
      end
      FINISH: begin
        o_done       = 1'b1;
        o_done_sb_id = sb_id_q;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // A load can never own more entries than the queue holds.
  a_ref_count_legal: assert property (@(posedge clk) disable iff (!reset_n)
    (state == IDLE && i_drain_req) |-> (32'(i_drain_ref_count) <= LQ_DEPTH));

endmodule
